// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module ifid_reg
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc4_in,
    input  logic [31:0] instr_in,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
);

    // Bubble wins over load; neither asserted means hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc4   <= 32'h0000_0000;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (bubble) begin
            ifid_pc4   <= pc4_in;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_pc4   <= pc4_in;
            ifid_instr <= instr_in;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem handshake FSM and IF/ID register.
//
//   state  | meaning
//   S_REQ  | requesting imem at pc, waiting for imem_ready
//   S_HOLD | instruction captured during a stall, request idle until release
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_busy
);

    fetch_state_t state, state_nxt;
    logic [31:0]  hold_instr;
    logic [31:0]  pc4;
    logic         pc_load;
    logic         hold_capture;
    logic         hold_drop;
    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  ifid_instr_in;

    assign pc4        = pc + 32'd4;
    assign imem_addr  = pc;
    assign imem_req   = (state == S_REQ);
    assign fetch_busy = (state == S_REQ) && !imem_ready;

    always_comb begin
        state_nxt     = state;
        pc_load       = 1'b0;
        hold_capture  = 1'b0;
        hold_drop     = 1'b0;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;
        ifid_instr_in = imem_rdata;
        unique case (state)
            S_REQ: begin
                if (flush) begin
                    ifid_bubble = 1'b1;
                    pc_load     = 1'b1;
                end else if (imem_ready) begin
                    if (stall) begin
                        hold_capture = 1'b1;
                        state_nxt    = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_load   = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                ifid_instr_in = hold_instr;
                if (flush) begin
                    hold_drop   = 1'b1;
                    ifid_bubble = 1'b1;
                    pc_load     = 1'b1;
                    state_nxt   = S_REQ;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_load   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            hold_instr <= NOP_INSTR;
        end else begin
            state <= state_nxt;
            if (pc_load)
                pc <= pc_next;
            if (hold_capture)
                hold_instr <= imem_rdata;
            else if (hold_drop)
                hold_instr <= NOP_INSTR;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .pc4_in     (pc4),
        .instr_in   (ifid_instr_in),
        .ifid_pc4   (ifid_pc4),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with hand-computed expectations.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_next;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fetch_busy;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_next    (pc_next),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid),
        .fetch_busy (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        ready;
        logic [31:0] rdata;
        logic [31:0] pcn;
        logic        e_req;
        logic        e_busy;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                              input logic [31:0] e_instr, input logic e_valid);
        check({tag, " pc"},         pc,                 e_pc);
        check({tag, " ifid_pc4"},   ifid_pc4,           e_pc4);
        check({tag, " ifid_instr"}, ifid_instr,         e_instr);
        check({tag, " ifid_valid"}, {31'b0, ifid_valid}, {31'b0, e_valid});
    endtask

    task automatic drive(input logic s, input logic f, input logic r,
                         input logic [31:0] d, input logic [31:0] pn);
        stall      = s;
        flush      = f;
        imem_ready = r;
        imem_rdata = d;
        pc_next    = pn;
    endtask

    initial begin
        //          stall flush rdy rdata          pcn            req busy addr           pc             pc4            instr          valid
        vecs[0]  = '{0, 0, 1, 32'h2001_0001, 32'h0000_0004, 1, 0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004, 32'h2001_0001, 1};
        vecs[1]  = '{0, 0, 1, 32'h2002_0002, 32'h0000_0008, 1, 0, 32'h0000_0004, 32'h0000_0008, 32'h0000_0008, 32'h2002_0002, 1};
        vecs[2]  = '{0, 0, 0, 32'hDEAD_BEEF, 32'h0000_000C, 1, 1, 32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 32'h0000_0000, 0};
        vecs[3]  = '{0, 0, 0, 32'hDEAD_BEEF, 32'h0000_000C, 1, 1, 32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 32'h0000_0000, 0};
        vecs[4]  = '{0, 0, 0, 32'hDEAD_BEEF, 32'h0000_000C, 1, 1, 32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 32'h0000_0000, 0};
        vecs[5]  = '{0, 0, 1, 32'h2003_0003, 32'h0000_000C, 1, 0, 32'h0000_0008, 32'h0000_000C, 32'h0000_000C, 32'h2003_0003, 1};
        vecs[6]  = '{0, 0, 1, 32'h0022_1820, 32'h0000_0010, 1, 0, 32'h0000_000C, 32'h0000_0010, 32'h0000_0010, 32'h0022_1820, 1};
        vecs[7]  = '{1, 0, 1, 32'h8C01_0004, 32'h0000_0014, 1, 0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0010, 32'h0022_1820, 1};
        vecs[8]  = '{1, 0, 0, 32'hBAD0_0001, 32'h0000_0014, 0, 0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0010, 32'h0022_1820, 1};
        vecs[9]  = '{1, 0, 1, 32'hBAD0_0002, 32'h0000_0014, 0, 0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0010, 32'h0022_1820, 1};
        vecs[10] = '{0, 0, 0, 32'hBAD0_0003, 32'h0000_0014, 0, 0, 32'h0000_0010, 32'h0000_0014, 32'h0000_0014, 32'h8C01_0004, 1};
        vecs[11] = '{1, 0, 1, 32'hAC02_0008, 32'h0000_0018, 1, 0, 32'h0000_0014, 32'h0000_0014, 32'h0000_0014, 32'h8C01_0004, 1};
        vecs[12] = '{1, 1, 0, 32'hBAD0_0004, 32'h0000_0040, 0, 0, 32'h0000_0014, 32'h0000_0040, 32'h0000_0018, 32'h0000_0000, 0};
        vecs[13] = '{0, 0, 1, 32'h1111_2222, 32'h0000_0044, 1, 0, 32'h0000_0040, 32'h0000_0044, 32'h0000_0044, 32'h1111_2222, 1};
        vecs[14] = '{0, 1, 1, 32'h3333_4444, 32'hFFFF_FFFC, 1, 0, 32'h0000_0044, 32'hFFFF_FFFC, 32'h0000_0048, 32'h0000_0000, 0};
        vecs[15] = '{0, 0, 1, 32'h5555_6666, 32'h0000_0000, 1, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 32'h5555_6666, 1};
        vecs[16] = '{1, 0, 0, 32'hBAD0_0005, 32'h0000_0020, 1, 1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h5555_6666, 1};
        vecs[17] = '{0, 1, 0, 32'hBAD0_0006, 32'h0000_0100, 1, 1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0004, 32'h0000_0000, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0);
        #12;
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset imem_req", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].flush, vecs[i].ready, vecs[i].rdata, vecs[i].pcn);
            #1;
            check($sformatf("v%0d imem_req", i),   {31'b0, imem_req},   {31'b0, vecs[i].e_req});
            check($sformatf("v%0d fetch_busy", i), {31'b0, fetch_busy}, {31'b0, vecs[i].e_busy});
            check($sformatf("v%0d imem_addr", i),  imem_addr,           vecs[i].e_addr);
            @(posedge clk);
            #1;
            check_ifid($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_instr, vecs[i].e_valid);
        end

        // Async reset while holding a captured instruction at pc 0x100.
        @(negedge clk);
        drive(1, 0, 1, 32'h7777_8888, 32'h0000_0104);
        @(posedge clk);
        #1;
        check("hold entry imem_req", {31'b0, imem_req}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_ifid("async reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("async reset imem_req", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        drive(0, 0, 1, 32'h9999_AAAA, 32'h0000_0004);
        rst_n = 1'b1;
        #1;
        check("post reset imem_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        check_ifid("post reset fetch", 32'h4, 32'h4, 32'h9999_AAAA, 1'b1);

        drive(0, 0, 0, 32'h0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
